fetcher: RTL and testbench
==========================

# fetcher

Instruction fetch stage of the out-of-order RV32I core. It owns the program counter and issues word fetches to the instruction cache. Each returned instruction is predecoded: JAL targets are computed locally, and conditional branches take their direction from the branch predictor. The block then hands {inst, addr, pred_jump} to the instruction queue through a valid/ready handshake. The ROB redirects it on mispredict or JALR resolution.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0, PC loaded at reset

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fet_icache_req_valid  out  1  fetch request valid
- fet_icache_addr  out  XLEN  word address of request (bits [1:0] always 0)
- icache_req_ready  in  1  request accepted when valid&&ready
- icache_resp_valid  in  1  one-cycle pulse; icache_inst valid
- icache_inst  in  32  fetched instruction
- fet_inst_addr  out  XLEN  PC of the instruction being predecoded, to branch predictor
- bp_pred  in  1  predictor direction for fet_inst_addr (1 = taken), combinational
- fet_iq_valid  out  1  instruction available to instruction queue
- fet_iq_inst  out  32  instruction word
- fet_iq_addr  out  XLEN  instruction PC
- fet_iq_pred_jump  out  1  fetcher redirected after this instruction
- iq_ready  in  1  queue accepts when valid&&ready
- rob_flush  in  1  redirect pulse
- rob_new_pc  in  XLEN  redirect target

## Operation
- States: REQ, WAIT, HOLD, HALT, DISCARD.
- REQ
  - Drive fet_icache_req_valid=1 with fet_icache_addr=pc.
  - On accept, go to WAIT.
- WAIT
  - On icache_resp_valid, predecode icache_inst (opcode = bits[6:0]).
  - 1101111 JAL: next_pc = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); pred_jump=1.
  - 1100011 branch: if bp_pred, then next_pc = pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}) and pred_jump=1; else next_pc = pc+4 and pred_jump=0.
  - 1100111 JALR: next_pc unchanged; pred_jump=0; fetch stops after issue.
  - Other opcodes: next_pc = pc+4; pred_jump=0.
  - Register the output {inst, pc, pred_jump} and go to HOLD.
- HOLD
  - fet_iq_valid=1; outputs are stable until accepted.
  - On accept: pc <= next_pc. Next state is HALT if the instruction was JALR, else REQ.
- HALT: idle, with no requests, until rob_flush.
- DISCARD: a request is outstanding but stale. Wait for icache_resp_valid, drop the instruction, then go to REQ.
- fet_inst_addr = pc in all states; the predictor reads it combinationally in WAIT.
- Arithmetic is modulo 2^XLEN; wrap-around past 32'hFFFF_FFFC is permitted silently.
- rob_flush has priority over every other event in the same cycle:
  - pc <= rob_new_pc and fet_iq_valid drops next cycle. A held instruction is discarded even if iq_ready=1 that cycle.
  - In WAIT, or in REQ with a request accepted that same cycle, go to DISCARD. If icache_resp_valid coincides with a flush in WAIT, the response is dropped and the next state is REQ.
  - From any other state, go to REQ.
  - A flush while in DISCARD updates pc and stays in DISCARD.
- Reset (any time, asynchronous): state=REQ, pc=RESET_PC, fet_icache_req_valid=0 during reset, fet_iq_valid=0, fet_iq_inst=0, fet_iq_addr=0, fet_iq_pred_jump=0. Any in-flight icache response after reset is the cache's responsibility; the cache is reset by the same rst_n.

## Timing
- First request is asserted in the first cycle after rst_n deasserts.
- Request to iq: the response cycle is N; fet_iq_valid is high from N+1.
- Fastest throughput is one instruction per 3 cycles with 1-cycle icache latency: REQ→WAIT→HOLD.
- bp_pred is sampled only in the cycle icache_resp_valid=1 in WAIT.
- Accept in HOLD: the next request issues the following cycle, with the new pc.
- Flush at cycle F: request for rob_new_pc issues at F+1, or after the stale response drains (DISCARD).

## Test plan
- Reset with RESET_PC=0, addi stream, icache 1-cycle, iq_ready=1 → requests at 0,4,8; fet_iq_addr 0,4,8; pred_jump=0.
- JAL at 0x10, imm=+0x20 → fet_iq_pred_jump=1; next request addr 0x30.
- BEQ at 0x40, imm=-8, bp_pred=1 → next request 0x38. Same case with bp_pred=0 → 0x44; fet_inst_addr=0x40 in the response cycle.
- iq_ready=0 for 5 cycles in HOLD → outputs stable and no new request. Flush rob_new_pc=0x100 during the stall → held instruction dropped, next request 0x100.
- JALR at 0x20 → issued to iq, then no requests. rob_flush with rob_new_pc=0x200 → request 0x200 next cycle.
- Flush during WAIT with a 3-cycle icache → stale response not forwarded; first request after the drain is rob_new_pc. Assert rst_n mid-WAIT → all outputs zero immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetcher_if.sv
// fetcher_if: fetcher bus bundle. master = fetcher side, slave = icache/predictor/iq/rob side.
// icache request (fet_icache_req_valid/fet_icache_addr/icache_req_ready),
// icache response (icache_resp_valid/icache_inst), predictor (fet_inst_addr/bp_pred),
// instruction queue (fet_iq_valid/fet_iq_inst/fet_iq_addr/fet_iq_pred_jump/iq_ready),
// ROB redirect (rob_flush/rob_new_pc).
interface fetcher_if #(parameter int XLEN = 32);
  logic fet_icache_req_valid;
  logic [XLEN-1:0] fet_icache_addr;
  logic icache_req_ready;
  logic icache_resp_valid;
  logic [31:0] icache_inst;
  logic [XLEN-1:0] fet_inst_addr;
  logic bp_pred;
  logic fet_iq_valid;
  logic [31:0] fet_iq_inst;
  logic [XLEN-1:0] fet_iq_addr;
  logic fet_iq_pred_jump;
  logic iq_ready;
  logic rob_flush;
  logic [XLEN-1:0] rob_new_pc;
  modport master (
    output fet_icache_req_valid, fet_icache_addr, fet_inst_addr,
    output fet_iq_valid, fet_iq_inst, fet_iq_addr, fet_iq_pred_jump,
    input icache_req_ready, icache_resp_valid, icache_inst, bp_pred, iq_ready, rob_flush, rob_new_pc
  );
  modport slave (
    input fet_icache_req_valid, fet_icache_addr, fet_inst_addr,
    input fet_iq_valid, fet_iq_inst, fet_iq_addr, fet_iq_pred_jump,
    output icache_req_ready, icache_resp_valid, icache_inst, bp_pred, iq_ready, rob_flush, rob_new_pc
  );
endinterface

// File: rtl/fetcher.sv
// fetcher: RV32I fetch stage; owns pc, fetches words from icache, predecodes JAL/branch/JALR, hands off to iq.
// Ports: clk, rst_n (async active-low), bus (fetcher_if.master: icache, predictor, iq and ROB redirect signals).
module fetcher #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  fetcher_if.master bus
);
  typedef enum logic [2:0] {REQ, WAIT, HOLD, HALT, DISCARD} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] pc, npc, tgt, jal_imm, br_imm;
  logic [31:0] inst, iq_inst;
  logic [XLEN-1:0] iq_addr;
  logic iq_pj, jalr_q, flush, resp, req_hs, iq_hs, is_jal, is_br, is_jalr, taken;
  assign inst = bus.icache_inst;
  assign flush = bus.rob_flush;
  assign resp = bus.icache_resp_valid;
  assign is_jal = inst[6:0] == 7'b1101111;
  assign is_br = inst[6:0] == 7'b1100011;
  assign is_jalr = inst[6:0] == 7'b1100111;
  assign jal_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign br_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign taken = is_jal | (is_br & bus.bp_pred);
  // JALR leaves pc untouched: the ROB supplies the real target via flush.
  assign tgt = is_jal ? pc + jal_imm : taken ? pc + br_imm : is_jalr ? pc : pc + XLEN'(4);
  // State sits at REQ while in reset, so the request is gated off by rst_n itself.
  assign bus.fet_icache_req_valid = rst_n && state == REQ;
  assign bus.fet_icache_addr = {pc[XLEN-1:2], 2'b00};
  assign bus.fet_inst_addr = pc;
  assign bus.fet_iq_valid = state == HOLD;
  assign bus.fet_iq_inst = iq_inst;
  assign bus.fet_iq_addr = iq_addr;
  assign bus.fet_iq_pred_jump = iq_pj;
  assign req_hs = bus.fet_icache_req_valid && bus.icache_req_ready;
  assign iq_hs = state == HOLD && bus.iq_ready && !flush;
  always_comb begin
    state_nx = state;
    case (state)
      REQ: state_nx = req_hs ? (flush ? DISCARD : WAIT) : REQ;
      WAIT: state_nx = flush ? (resp ? REQ : DISCARD) : resp ? HOLD : WAIT;
      HOLD: state_nx = flush ? REQ : bus.iq_ready ? (jalr_q ? HALT : REQ) : HOLD;
      HALT: state_nx = flush ? REQ : HALT;
      // A response arriving with a flush still drains the stale request, so leave DISCARD.
      DISCARD: state_nx = resp ? REQ : DISCARD;
      default: state_nx = REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ;
      pc <= RESET_PC;
      npc <= '0;
      jalr_q <= 1'b0;
      iq_inst <= '0;
      iq_addr <= '0;
      iq_pj <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= flush ? bus.rob_new_pc : iq_hs ? npc : pc;
      if (state == WAIT && resp && !flush) begin
        npc <= tgt;
        jalr_q <= is_jalr;
        iq_inst <= inst;
        iq_addr <= pc;
        iq_pj <= taken;
      end
    end
  end
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: randomized icache/iq/flush traffic against an instruction-level model of the fetch stream.
module tb_fetcher;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetcher_if #(.XLEN(32)) bus ();
  fetcher #(.XLEN(32), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.bp_pred = bus.fet_inst_addr[2] ^ bus.fet_inst_addr[5];
  logic [31:0] mem [256];
  int kind [256];
  logic [31:0] off [256];
  int pass = 0;
  int total = 0;
  logic [31:0] exp_pc;
  logic halted;
  logic pend;
  logic [31:0] paddr;
  int lat;
  int p_iq = 70;
  int p_fl = 3;
  int p_rr = 70;
  logic fix_en = 1'b0;
  logic [31:0] fix_pc = 32'h0;
  logic req_hs;
  int idle = 0;
  logic [31:0] s_inst, s_addr;
  logic s_pj;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic gen(input int i);
    int r, o;
    logic [31:0] im, rnd;
    r = $urandom_range(0, 19);
    o = (int'($urandom_range(0, 127)) - 64) * 4;
    im = o;
    rnd = $urandom;
    off[i] = im;
    kind[i] = r < 10 ? 0 : r < 14 ? 2 : r < 18 ? 1 : 3;
    case (kind[i])
      1: mem[i] = {im[20], im[10:1], im[11], im[19:12], rnd[11:7], 7'b1101111};
      2: mem[i] = {im[12], im[10:5], rnd[24:12], im[4:1], im[11], 7'b1100011};
      3: mem[i] = {rnd[31:15], 3'b000, rnd[11:7], 7'b1100111};
      default: mem[i] = {rnd[31:7], rnd[0] ? 7'b0110011 : 7'b0010011};
    endcase
  endtask

  task automatic cycle();
    logic fl, resp_now, pj;
    logic [7:0] idx;
    logic [31:0] req_addr;
    int k;
    bus.icache_req_ready = $urandom_range(0, 99) < p_rr;
    bus.icache_resp_valid = pend && lat == 0;
    bus.icache_inst = pend ? mem[paddr[9:2]] : 32'h0;
    bus.iq_ready = $urandom_range(0, 99) < p_iq;
    fl = $urandom_range(0, 99) < (halted ? 20 : p_fl);
    bus.rob_flush = fl;
    bus.rob_new_pc = fix_en ? fix_pc : ($urandom & 32'hFFFF_FFFC);
    #4;
    check("inst_addr", bus.fet_inst_addr, exp_pc);
    if (halted) check("halt_no_req", bus.fet_icache_req_valid, 0);
    req_hs = bus.fet_icache_req_valid && bus.icache_req_ready;
    req_addr = bus.fet_icache_addr;
    if (req_hs) check("req_addr", req_addr, exp_pc);
    if (bus.fet_iq_valid && bus.iq_ready && !fl) begin
      idx = exp_pc[9:2];
      k = kind[idx];
      pj = k == 1 || (k == 2 && (exp_pc[2] ^ exp_pc[5]));
      check("iq_addr", bus.fet_iq_addr, exp_pc);
      check("iq_inst", bus.fet_iq_inst, mem[idx]);
      check("iq_pred_jump", bus.fet_iq_pred_jump, pj);
      exp_pc = pj ? exp_pc + off[idx] : k == 3 ? exp_pc : exp_pc + 4;
      halted = k == 3;
      idle = 0;
    end else if (!halted) idle++;
    if (idle > 300) begin
      total++;
      $error("FAIL liveness: no instruction delivered for %0d cycles", idle);
      idle = 0;
    end
    if (fl) begin
      exp_pc = bus.rob_new_pc;
      halted = 1'b0;
    end
    resp_now = bus.icache_resp_valid;
    @(posedge clk);
    #1;
    if (resp_now) pend = 1'b0;
    else if (pend) lat--;
    if (req_hs) begin
      pend = 1'b1;
      paddr = req_addr;
      lat = $urandom_range(0, 2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, bus.fet_icache_req_valid, 0);
    check({tag, "_iq_valid"}, bus.fet_iq_valid, 0);
    check({tag, "_iq_inst"}, bus.fet_iq_inst, 0);
    check({tag, "_iq_addr"}, bus.fet_iq_addr, 0);
    check({tag, "_iq_pj"}, bus.fet_iq_pred_jump, 0);
    check({tag, "_pc"}, bus.fet_inst_addr, RESET_PC);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) gen(i);
    exp_pc = RESET_PC;
    halted = 1'b0;
    pend = 1'b0;
    lat = 0;
    req_hs = 1'b0;
    bus.icache_req_ready = 1'b0;
    bus.icache_resp_valid = 1'b0;
    bus.icache_inst = 32'h0;
    bus.iq_ready = 1'b0;
    bus.rob_flush = 1'b0;
    bus.rob_new_pc = 32'h0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("first_req_valid", bus.fet_icache_req_valid, 1);
    check("first_req_addr", bus.fet_icache_addr, RESET_PC);
    repeat (3000) cycle();
    p_iq = 0;
    p_fl = 0;
    for (int n = 0; n < 200 && !bus.fet_iq_valid; n++) cycle();
    check("stall_in_hold", bus.fet_iq_valid, 1);
    s_inst = bus.fet_iq_inst;
    s_addr = bus.fet_iq_addr;
    s_pj = bus.fet_iq_pred_jump;
    repeat (5) begin
      cycle();
      check("stall_valid", bus.fet_iq_valid, 1);
      check("stall_inst", bus.fet_iq_inst, s_inst);
      check("stall_addr", bus.fet_iq_addr, s_addr);
      check("stall_pj", bus.fet_iq_pred_jump, s_pj);
      check("stall_no_req", bus.fet_icache_req_valid, 0);
    end
    p_iq = 100;
    p_fl = 100;
    p_rr = 100;
    fix_en = 1'b1;
    fix_pc = 32'h100;
    cycle();
    p_fl = 0;
    check("flush_drop_valid", bus.fet_iq_valid, 0);
    check("flush_req_valid", bus.fet_icache_req_valid, 1);
    check("flush_req_addr", bus.fet_icache_addr, 32'h100);
    p_iq = 70;
    p_fl = 3;
    p_rr = 70;
    fix_en = 1'b0;
    repeat (1000) cycle();
    p_fl = 0;
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (req_hs) break;
    end
    check("midwait_reached", req_hs, 1);
    bus.icache_resp_valid = 1'b0;
    bus.icache_req_ready = 1'b0;
    bus.rob_flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midwait_rst");
    pend = 1'b0;
    exp_pc = RESET_PC;
    halted = 1'b0;
    idle = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("restart_req_valid", bus.fet_icache_req_valid, 1);
    check("restart_req_addr", bus.fet_icache_addr, RESET_PC);
    p_fl = 3;
    repeat (1000) cycle();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
